// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - XGA 1024x768@60 raster constants shared by the timing and draw stages
// Derived totals live here so downstream stages never hard-code boundary pixels.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOT    = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOT    = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  typedef logic [CNT_W-1:0] count_t;

  function automatic count_t to_count(input int value);
    return count_t'(value);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running raster counter with zero-skew registered sync/blank strobes
// Strobes are decoded from the next-count values so they land on the same edge as the counters.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_LAST     = to_count(H_TOT - 1);
  localparam count_t V_LAST     = to_count(V_TOT - 1);
  localparam count_t H_BLK_BEG  = to_count(H_ACTIVE);
  localparam count_t V_BLK_BEG  = to_count(V_ACTIVE);
  localparam count_t H_SYNC_BEG = to_count(H_ACTIVE + H_FP);
  localparam count_t H_SYNC_END = to_count(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t V_SYNC_BEG = to_count(V_ACTIVE + V_FP);
  localparam count_t V_SYNC_END = to_count(V_ACTIVE + V_FP + V_SYNC);
  localparam count_t CNT_ONE    = to_count(1);

  count_t h_next;
  count_t v_next;
  logic   h_wrap;
  logic   v_wrap;
  logic   hsync_next;
  logic   vsync_next;
  logic   hblnk_next;
  logic   vblnk_next;
  logic   frame_next;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? '0 : hcount + CNT_ONE;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + CNT_ONE;
    end
  end

  // Decode against the value the counters are about to take, never the registered ones.
  always_comb begin
    hblnk_next = (h_next >= H_BLK_BEG);
    vblnk_next = (v_next >= V_BLK_BEG);
    hsync_next = ((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next = ((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    frame_next = (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= frame_next;
    end
  end

endmodule
